// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    // Pick the 32-bit instruction out of an aligned doubleword by pc[2].
    function automatic logic [31:0] select_word(input logic [63:0] data, input logic hi);
        return hi ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// rtl/ifu_fetch_fifo.sv - small {pc, inst} buffer between fetch and decode
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write one entry at the tail
//   pop             remove the head entry
//   flush           empty the buffer; overrides a same-cycle push/pop
//   count           number of valid entries (0..DEPTH)
//   head            head entry, all-zero while empty
module ifu_fetch_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t     mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Storage is not reset; gating keeps inst/inst_pc at zero while empty.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifu_fetch_unit.sv
// rtl/ifu_fetch_unit.sv - fetch PC, one-outstanding memory request FSM, decode buffer
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/ready/addr     doubleword read request toward instruction memory
//   resp_valid/resp_data     one response per accepted request, no backpressure
//   inst_valid/ready         head of the decode buffer handshake
//   inst, inst_pc            instruction word and its PC
//   redirect_valid/pc        new fetch PC from execute; flushes everything in flight
module ifu_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = IFU_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [63:0] req_addr,
    input  logic        resp_valid,
    input  logic [63:0] resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    state_n;
    logic [63:0]     pc;
    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    push_data;
    logic            handshake;
    logic            push;
    logic            pop;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Issuing only with a free slot means the single outstanding response
    // always has room, so resp never needs backpressure.
    assign req_valid = (state == REQ) && (count < CW'(FIFO_DEPTH));
    assign req_addr  = {pc[63:3], 3'b000};
    assign handshake = req_valid && req_ready;

    // A response in the redirect cycle belongs to the old path and is dropped.
    assign push      = (state == WAIT) && resp_valid && !redirect_valid;
    assign pop       = inst_valid && inst_ready;

    assign push_data.pc   = pc;
    assign push_data.inst = select_word(resp_data, pc[2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_n;
            if (redirect_valid) begin
                pc <= {redirect_pc[63:2], 2'b00};
            end else if (push) begin
                pc <= pc + 64'd4;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = REQ;
            REQ: begin
                // An accepted request under redirect still owes a response.
                if (handshake) begin
                    state_n = redirect_valid ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (resp_valid) begin
                    state_n = REQ;
                end else if (redirect_valid) begin
                    state_n = DROP;
                end
            end
            DROP: begin
                if (resp_valid) begin
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    ifu_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    assign inst_valid = (count != '0);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// tb/tb_ifu_fetch_unit.sv - self-checking bench for ifu_fetch_unit
module tb_ifu_fetch_unit;
    import ifu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    ifu_fetch_unit #(
        .RESET_PC   (64'h8000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hC3C3_0000, ~a[31:0]};
    endfunction

    // Memory model: responds once per accepted request after mem_lat cycles.
    int          mem_lat;
    logic        fixed_en;
    logic [63:0] fixed_data;
    logic        hs_seen;
    logic [63:0] hs_addr;
    logic        pend;
    int          cnt;
    logic [63:0] paddr;

    always @(posedge clk) begin
        #1;
        resp_valid = 1'b0;
        if (rst) begin
            pend    = 1'b0;
            hs_seen = 1'b0;
        end else begin
            if (hs_seen) begin
                pend    = 1'b1;
                cnt     = mem_lat;
                paddr   = hs_addr;
                hs_seen = 1'b0;
            end
            if (pend) begin
                if (cnt <= 1) begin
                    resp_valid = 1'b1;
                    resp_data  = fixed_en ? fixed_data : mem_word(paddr);
                    pend       = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Scoreboard: expected entry queued when a live response is driven,
    // popped and compared when decode consumes the head.
    fetch_entry_t sb[$];
    logic [63:0]  exp_pc;
    logic         live;

    always @(negedge clk) begin
        fetch_entry_t e;
        if (rst) begin
            sb.delete();
            exp_pc = 64'h8000_0000;
            live   = 1'b0;
        end else begin
            if (inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got inst_pc %h with nothing expected", inst_pc);
                end else begin
                    e = sb.pop_front();
                    check("sb_pc", inst_pc, e.pc);
                    check("sb_inst", {32'h0, inst}, {32'h0, e.inst});
                end
            end
            if (req_valid && req_ready) begin
                check("req_addr", req_addr, {exp_pc[63:3], 3'b000});
                hs_seen = 1'b1;
                hs_addr = req_addr;
                live    = 1'b1;
            end
            if (resp_valid && live) begin
                e.pc   = exp_pc;
                e.inst = exp_pc[2] ? resp_data[63:32] : resp_data[31:0];
                sb.push_back(e);
                exp_pc = exp_pc + 64'd4;
                live   = 1'b0;
            end
            if (redirect_valid) begin
                sb.delete();
                exp_pc = {redirect_pc[63:2], 2'b00};
                live   = 1'b0;
            end
        end
    end

    task automatic wait_inst(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inst_valid && n < 100);
        if (!inst_valid) begin
            total++;
            bad++;
            $display("FAIL %s: got no inst_valid in 100 cycles expected inst_valid", name);
        end
    endtask

    task automatic redirect_now(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk);
        #2 redirect_valid = 1'b0;
        @(negedge clk);
        check("redirect_flush_valid", {63'h0, inst_valid}, 64'h0);
    endtask

    typedef struct {
        logic [63:0] rpc;
        logic [63:0] data;
        int          lat;
        logic [63:0] epc;
        logic [31:0] einst;
    } vec_t;

    vec_t        vt[4];
    logic [63:0] cap_pc;
    logic [31:0] cap_inst;
    logic        cap_ok;
    logic [63:0] w;
    int          n;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        req_ready      = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        resp_valid     = 1'b0;
        resp_data      = '0;
        fixed_en       = 1'b1;
        fixed_data     = 64'hAAAA_BBBB_1111_2222;
        mem_lat        = 1;
        hs_seen        = 1'b0;
        hs_addr        = '0;
        pend           = 1'b0;
        cnt            = 0;
        paddr          = '0;

        vt[0] = '{64'h8000_0203, 64'h1234_5678_9ABC_DEF0, 1, 64'h8000_0200, 32'h9ABC_DEF0};
        vt[1] = '{64'h8000_0106, 64'hDEAD_BEEF_CAFE_F00D, 2, 64'h8000_0104, 32'hDEAD_BEEF};
        vt[2] = '{64'h8000_0FFE, {INST_NOP, 32'hFFFF_FFFF}, 3, 64'h8000_0FFC, INST_NOP};
        vt[3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0123_4567_89AB_CDEF, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0123_4567};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", {63'h0, req_valid}, 64'h0);
        check("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
        check("rst_inst", {32'h0, inst}, 64'h0);
        check("rst_inst_pc", inst_pc, 64'h0);
        check("rst_req_addr", req_addr, 64'h8000_0000);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("idle_req_valid", {63'h0, req_valid}, 64'h0);
        @(negedge clk);
        check("first_req_valid", {63'h0, req_valid}, 64'h1);
        check("first_req_addr", req_addr, 64'h8000_0000);

        // Basic fetch, word select by pc[2]
        wait_inst("t1_first");
        check("t1_first_inst", {32'h0, inst}, 64'h1111_2222);
        check("t1_first_pc", inst_pc, 64'h8000_0000);
        wait_inst("t1_second");
        check("t1_second_inst", {32'h0, inst}, 64'hAAAA_BBBB);
        check("t1_second_pc", inst_pc, 64'h8000_0004);

        // Decode stall: buffer fills to two, requests stop, head stable
        fixed_en = 1'b0;
        @(posedge clk);
        #2 inst_ready = 1'b0;
        cap_ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst_valid && !cap_ok) begin
                cap_pc   = inst_pc;
                cap_inst = inst;
                cap_ok   = 1'b1;
            end
        end
        check("stall_req_valid", {63'h0, req_valid}, 64'h0);
        check("stall_inst_valid", {63'h0, inst_valid}, 64'h1);
        check("stall_head_pc", inst_pc, 64'h8000_0008);
        check("stall_pc_stable", inst_pc, cap_pc);
        check("stall_inst_stable", {32'h0, inst}, {32'h0, cap_inst});
        @(posedge clk);
        #2 inst_ready = 1'b1;
        @(negedge clk);
        check("drain0_valid", {63'h0, inst_valid}, 64'h1);
        check("drain0_pc", inst_pc, 64'h8000_0008);
        @(negedge clk);
        check("drain1_valid", {63'h0, inst_valid}, 64'h1);
        check("drain1_pc", inst_pc, 64'h8000_000C);
        @(negedge clk);
        check("drain_empty", {63'h0, inst_valid}, 64'h0);

        // Redirect while waiting on a slow response
        mem_lat = 3;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req_valid && req_ready) && n < 100);
        check("t3_found_req", {63'h0, req_valid && req_ready}, 64'h1);
        @(posedge clk);
        #2 redirect_now(64'h8000_0100);
        wait_inst("t3_inst");
        w = mem_word(64'h8000_0100);
        check("t3_pc", inst_pc, 64'h8000_0100);
        check("t3_inst", {32'h0, inst}, {32'h0, w[31:0]});

        // Redirect in the same cycle as a response and a pop
        mem_lat = 2;
        @(posedge clk);
        #2 inst_ready = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(resp_valid && inst_valid) && n < 100);
        check("t4_found_overlap", {63'h0, resp_valid && inst_valid}, 64'h1);
        inst_ready = 1'b1;
        redirect_now(64'h8000_0300);
        check("t4_req_valid", {63'h0, req_valid}, 64'h1);
        check("t4_req_addr", req_addr, 64'h8000_0300);
        wait_inst("t4_inst");
        check("t4_pc", inst_pc, 64'h8000_0300);

        // Redirect table: misaligned targets, word select, PC wrap
        fixed_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_lat    = vt[i].lat;
            fixed_data = vt[i].data;
            @(posedge clk);
            #2 redirect_now(vt[i].rpc);
            wait_inst("vec_inst");
            check($sformatf("vec%0d_pc", i), inst_pc, vt[i].epc);
            check($sformatf("vec%0d_inst", i), {32'h0, inst}, {32'h0, vt[i].einst});
        end
        wait_inst("wrap_inst");
        check("wrap_pc", inst_pc, 64'h0);

        // Reset mid-operation with a buffered entry and a request in flight
        fixed_en = 1'b0;
        mem_lat  = 3;
        @(posedge clk);
        #2 inst_ready = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(dut.state == WAIT && inst_valid) && n < 100);
        check("t6_found_wait", {63'h0, dut.state == WAIT && inst_valid}, 64'h1);
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("t6_inst_valid", {63'h0, inst_valid}, 64'h0);
        check("t6_req_valid", {63'h0, req_valid}, 64'h0);
        check("t6_state", {62'h0, dut.state}, {62'h0, IDLE});
        check("t6_inst", {32'h0, inst}, 64'h0);
        @(negedge clk);
        check("t6_req_valid_after", {63'h0, req_valid}, 64'h1);
        check("t6_req_addr", req_addr, 64'h8000_0000);
        inst_ready = 1'b1;
        wait_inst("t6_inst_after");
        check("t6_pc_after", inst_pc, 64'h8000_0000);
        wait_inst("t6_inst_next");
        check("t6_pc_next", inst_pc, 64'h8000_0004);
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
